spi_slave: RTL

//  SPI target (slave) end of the existing SPI master link. Oversamples sclk/ss/mosi in the

---
 rtl/spi_slave.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI target: oversampled pins, all CPOL/CPHA modes, one-deep tx holding register
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift frames LSB first (default MSB first).
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tx_sh_q, tx_sh_d;
  // Only DATA_WIDTH-1 bits need storing: the final bit comes straight from s_mosi.
  logic [DATA_WIDTH-2:0]  rx_part_q, rx_part_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;

  logic                   s_sclk, s_ss, s_mosi;
  logic                   sclk_toggle, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge;
  logic                   ss_fall, abort, tx_accept;
  logic                   tx_bit;
  logic [DATA_WIDTH-1:0]  tx_next, rx_next;
  logic [DATA_WIDTH-2:0]  rx_keep;

  // Synchronizer chains and one-clk delayed copies for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = s_sclk;
    ss_prev_d   = s_ss;
  end

  assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign s_ss   = ss_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it; CPHA picks which samples
  always_comb begin
    sclk_toggle = s_sclk ^ sclk_prev_q;
    lead_edge   = sclk_toggle & (s_sclk != CPOL);
    trail_edge  = sclk_toggle & (s_sclk == CPOL);
    sample_edge = CPHA ? trail_edge : lead_edge;
    shift_edge  = CPHA ? lead_edge : trail_edge;
    ss_fall     = ss_prev_q & ~s_ss;
    abort       = s_ss & (state_q != IDLE);
    tx_accept   = tx_valid & ~hold_full_q;
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign tx_bit  = tx_sh_q[0];
  assign tx_next = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
  assign rx_next = {s_mosi, rx_part_q};
  assign rx_keep = rx_next[DATA_WIDTH-1:1];
`else
  assign tx_bit  = tx_sh_q[DATA_WIDTH-1];
  assign tx_next = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_next = {rx_part_q, s_mosi};
  assign rx_keep = rx_next[DATA_WIDTH-2:0];
`endif

  // Frame FSM, shift registers, bit counter and tx holding register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_part_d   = rx_part_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      tx_sh_d   = '0;
      rx_part_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) state_d = LOAD;
        end
        LOAD: begin
          if (hold_full_q) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_sh_d    = '0;
            underrun_d = 1'b1;
          end
          cnt_d     = '0;
          rx_part_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_part_d = rx_keep;
            if (cnt_q == LAST_BIT) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
              state_d    = LOAD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // A shift edge before any sample of this frame is either the first CPHA=1
          // leading edge or the CPHA=0 trailing edge that closed the previous frame.
          if (shift_edge && (cnt_q != '0)) tx_sh_d = tx_next;
        end
        default: state_d = IDLE;
      endcase
    end

    // Only possible while empty, so a same-clk LOAD has already taken the old content
    if (tx_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers; synchronizers preset to the idle pin levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_part_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_part_q   <= rx_part_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso_oe     = ~s_ss & (state_q != IDLE);
  assign miso        = miso_oe & tx_bit;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = (state_q != IDLE);

endmodule
